// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU execution datapath.
//   - WORD_WIDTH_DEF : default datapath width
//   - ALU_*          : 4-bit ALU opcode encodings
//   - FLAG_*         : bit positions inside the 5-bit flag vector {P,V,S,Z,C}
//   - even_parity8   : 1 when a byte holds an even number of ones
package cpu_pkg;

  localparam int WORD_WIDTH_DEF = 32;
  localparam int FLAG_WIDTH_DEF = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_ADC  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_SBB  = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_OR   = 4'h5;
  localparam logic [3:0] ALU_XOR  = 4'h6;
  localparam logic [3:0] ALU_NOT  = 4'h7;
  localparam logic [3:0] ALU_SHL  = 4'h8;
  localparam logic [3:0] ALU_SHR  = 4'h9;
  localparam logic [3:0] ALU_SAR  = 4'hA;
  localparam logic [3:0] ALU_ROL  = 4'hB;
  localparam logic [3:0] ALU_ROR  = 4'hC;
  localparam logic [3:0] ALU_INC  = 4'hD;
  localparam logic [3:0] ALU_DEC  = 4'hE;
  localparam logic [3:0] ALU_PASS = 4'hF;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_P = 4;

  function automatic logic even_parity8(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/temp_reg.sv
// temp_reg: word-wide temporary register with write enable and gated read port.
//   clk, rst      : clock, synchronous active-high reset (wins over we)
//   we, data_in   : load data_in on the next posedge
//   oe, data_out  : data_out shows the stored word when oe=1, else 0
module temp_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             oe,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= data_in;
  end

  // Plain AND gating, no tri-state: a disabled register reads as zero.
  assign data_out = oe ? q : '0;

endmodule

// File: rtl/t_reg_alu_datapath.sv
// t_reg_alu_datapath: two temporary registers T1/T2 feeding a combinational ALU.
//   clk, rst                      : clock, synchronous active-high reset
//   t1_we/t1_oe/t1_in/t1_out      : T1 write/read; t1_out is ALU operand A
//   t2_we/t2_oe/t2_in/t2_out      : T2 write/read; t2_out is ALU operand B
//   alu_oe, alu_opcode, alu_carry : result gate, operation, carry/borrow in
//   alu_out                       : result when alu_oe=1, else 0
//   alu_flags                     : {P,V,S,Z,C}, computed regardless of alu_oe
module t_reg_alu_datapath
  import cpu_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int FLAG_WIDTH = FLAG_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  t1_we,
  input  logic                  t1_oe,
  input  logic [WORD_WIDTH-1:0] t1_in,
  output logic [WORD_WIDTH-1:0] t1_out,
  input  logic                  t2_we,
  input  logic                  t2_oe,
  input  logic [WORD_WIDTH-1:0] t2_in,
  output logic [WORD_WIDTH-1:0] t2_out,
  input  logic                  alu_oe,
  input  logic [3:0]            alu_opcode,
  input  logic                  alu_carry,
  output logic [WORD_WIDTH-1:0] alu_out,
  output logic [FLAG_WIDTH-1:0] alu_flags
);

  localparam int               M   = WORD_WIDTH - 1;
  localparam int               SHW = $clog2(WORD_WIDTH);
  localparam logic [SHW:0]     WL  = WORD_WIDTH[SHW:0];
  localparam logic [WORD_WIDTH:0] ONE_X = 1;

  temp_reg #(.WIDTH(WORD_WIDTH)) u_t1 (
    .clk(clk), .rst(rst), .we(t1_we), .oe(t1_oe), .data_in(t1_in), .data_out(t1_out)
  );

  temp_reg #(.WIDTH(WORD_WIDTH)) u_t2 (
    .clk(clk), .rst(rst), .we(t2_we), .oe(t2_oe), .data_in(t2_in), .data_out(t2_out)
  );

  logic [WORD_WIDTH-1:0] a, b, res;
  logic [WORD_WIDTH:0]   ext, cin_x;
  logic [SHW-1:0]        sh;
  logic [SHW:0]          rot_amt;
  logic                  c, v;

  // Operands are the gated register outputs, so a disabled register is 0.
  assign a       = t1_out;
  assign b       = t2_out;
  assign sh      = b[SHW-1:0];
  assign rot_amt = WL - {1'b0, sh};
  assign cin_x   = {{WORD_WIDTH{1'b0}}, alu_carry};

  always_comb begin
    res = a;
    c   = 1'b0;
    v   = 1'b0;
    ext = '0;
    case (alu_opcode)
      ALU_ADD: begin
        {c, res} = {1'b0, a} + {1'b0, b};
        v = (a[M] == b[M]) && (res[M] != a[M]);
      end
      ALU_ADC: begin
        {c, res} = {1'b0, a} + {1'b0, b} + cin_x;
        v = (a[M] == b[M]) && (res[M] != a[M]);
      end
      // Top bit of the (W+1)-bit difference is set exactly when it went negative.
      ALU_SUB: begin
        {c, res} = {1'b0, a} - {1'b0, b};
        v = (a[M] != b[M]) && (res[M] != a[M]);
      end
      ALU_SBB: begin
        {c, res} = {1'b0, a} - {1'b0, b} - cin_x;
        v = (a[M] != b[M]) && (res[M] != a[M]);
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_NOT: res = ~a;
      // Shifts run through a one-bit extension that catches the last bit
      // shifted out; with a zero amount that bit stays 0.
      ALU_SHL: begin
        ext = {1'b0, a} << sh;
        res = ext[M:0];
        c   = ext[WORD_WIDTH];
      end
      ALU_SHR: begin
        ext = {a, 1'b0} >> sh;
        res = ext[WORD_WIDTH:1];
        c   = ext[0];
      end
      ALU_SAR: begin
        ext = $signed({a, 1'b0}) >>> sh;
        res = ext[WORD_WIDTH:1];
        c   = ext[0];
      end
      // Rotate-out bit lands at the opposite end of the result.
      ALU_ROL: begin
        res = (a << sh) | (a >> rot_amt);
        c   = (sh != '0) & res[0];
      end
      ALU_ROR: begin
        res = (a >> sh) | (a << rot_amt);
        c   = (sh != '0) & res[M];
      end
      ALU_INC: begin
        {c, res} = {1'b0, a} + ONE_X;
        v = ~a[M] & res[M];
      end
      ALU_DEC: begin
        {c, res} = {1'b0, a} - ONE_X;
        v = a[M] & ~res[M];
      end
      ALU_PASS: res = a;
      default:  res = a;
    endcase
  end

  assign alu_out = alu_oe ? res : '0;

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = c;
    alu_flags[FLAG_Z] = (res == '0);
    alu_flags[FLAG_S] = res[M];
    alu_flags[FLAG_V] = v;
    alu_flags[FLAG_P] = even_parity8(res[7:0]);
  end

endmodule

// File: tb/tb_t_reg_alu_datapath.sv
module tb_t_reg_alu_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        t1_we = 1'b0, t1_oe = 1'b0, t2_we = 1'b0, t2_oe = 1'b0;
  logic [31:0] t1_in = '0, t2_in = '0;
  logic [31:0] t1_out, t2_out, alu_out;
  logic        alu_oe = 1'b0, alu_carry = 1'b0;
  logic [3:0]  alu_opcode = 4'h0;
  logic [4:0]  alu_flags;

  int vectors = 0;
  int miscompares = 0;

  t_reg_alu_datapath dut (
    .clk(clk), .rst(rst),
    .t1_we(t1_we), .t1_oe(t1_oe), .t1_in(t1_in), .t1_out(t1_out),
    .t2_we(t2_we), .t2_oe(t2_oe), .t2_in(t2_in), .t2_out(t2_out),
    .alu_oe(alu_oe), .alu_opcode(alu_opcode), .alu_carry(alu_carry),
    .alu_out(alu_out), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // Reference ALU: wide integer arithmetic, signed range checks for V and
  // bit-at-a-time shifting for the shift/rotate family.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] r, output logic [4:0] f);
    longint unsigned ua = {32'h0, a};
    longint unsigned ub = {32'h0, b};
    longint unsigned uc = {63'h0, cin};
    longint unsigned t;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint sc = longint'(cin);
    longint st = 0;
    bit chk_v = 0;
    bit c = 0;
    int n = int'(b[4:0]);
    r = a;
    case (op)
      4'h0: begin t = ua + ub;      r = t[31:0]; c = t[32]; st = sa + sb;      chk_v = 1; end
      4'h1: begin t = ua + ub + uc; r = t[31:0]; c = t[32]; st = sa + sb + sc; chk_v = 1; end
      4'h2: begin r = a - b;        c = (ua < ub);      st = sa - sb;      chk_v = 1; end
      4'h3: begin r = a - b - {31'h0, cin}; c = (ua < ub + uc); st = sa - sb - sc; chk_v = 1; end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: for (int i = 0; i < n; i++) begin c = r[31]; r = r << 1; end
      4'h9: for (int i = 0; i < n; i++) begin c = r[0]; r = r >> 1; end
      4'hA: for (int i = 0; i < n; i++) begin c = r[0]; r = {r[31], r[31:1]}; end
      4'hB: for (int i = 0; i < n; i++) begin c = r[31]; r = {r[30:0], r[31]}; end
      4'hC: for (int i = 0; i < n; i++) begin c = r[0]; r = {r[0], r[31:1]}; end
      4'hD: begin t = ua + 1; r = t[31:0]; c = t[32]; st = sa + 1; chk_v = 1; end
      4'hE: begin r = a - 32'd1; c = (a == 32'd0); st = sa - 1; chk_v = 1; end
      default: r = a;
    endcase
    f[0] = c;
    f[1] = (r == 32'd0);
    f[2] = r[31];
    f[3] = chk_v && (st > 64'sd2147483647 || st < -64'sd2147483648);
    f[4] = ($countones(r[7:0]) % 2) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    t1_in = a; t2_in = b; t1_we = 1'b1; t2_we = 1'b1;
    tick();
    t1_we = 1'b0; t2_we = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t1_oe = 1'b1; t2_oe = 1'b1;
    #1;
    vectors++;
    if (t1_out !== 32'h0) begin miscompares++; $display("FAIL reset_t1 got %h want %h", t1_out, 32'h0); end
    vectors++;
    if (t2_out !== 32'h0) begin miscompares++; $display("FAIL reset_t2 got %h want %h", t2_out, 32'h0); end
  endtask

  task automatic test_write_hold();
    t1_oe = 1'b0; t2_oe = 1'b0;
    load(32'd5, 32'd6);
    vectors++;
    if (t1_out !== 32'h0) begin miscompares++; $display("FAIL oe_off_t1 got %h want %h", t1_out, 32'h0); end
    t1_oe = 1'b1; t2_oe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (t1_out !== 32'd5) begin miscompares++; $display("FAIL hold_t1 cyc %0d got %h want %h", i, t1_out, 32'd5); end
      vectors++;
      if (t2_out !== 32'd6) begin miscompares++; $display("FAIL hold_t2 cyc %0d got %h want %h", i, t2_out, 32'd6); end
      tick();
    end
  endtask

  task automatic test_add();
    t1_oe = 1'b1; t2_oe = 1'b1; alu_oe = 1'b1; alu_opcode = 4'h0; alu_carry = 1'b0;
    #1;
    vectors++;
    if (alu_out !== 32'd11) begin miscompares++; $display("FAIL add_out got %h want %h", alu_out, 32'd11); end
    vectors++;
    if (alu_flags !== 5'b00000) begin miscompares++; $display("FAIL add_flags got %b want %b", alu_flags, 5'b00000); end
    alu_oe = 1'b0;
    #1;
    vectors++;
    if (alu_out !== 32'd0) begin miscompares++; $display("FAIL add_gated_out got %h want %h", alu_out, 32'd0); end
    vectors++;
    if (alu_flags !== 5'b00000) begin miscompares++; $display("FAIL add_gated_flags got %b want %b", alu_flags, 5'b00000); end
    alu_oe = 1'b1;
  endtask

  task automatic test_sub_borrow();
    alu_opcode = 4'h2;
    #1;
    vectors++;
    if (alu_out !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sub_out got %h want %h", alu_out, 32'hFFFF_FFFF); end
    // {P,V,S,Z,C} = 1,0,1,0,1
    vectors++;
    if (alu_flags !== 5'b10101) begin miscompares++; $display("FAIL sub_flags got %b want %b", alu_flags, 5'b10101); end
  endtask

  task automatic test_overflow_zero();
    load(32'h7FFF_FFFF, 32'h1);
    alu_opcode = 4'h0;
    #1;
    vectors++;
    if (alu_out !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_out got %h want %h", alu_out, 32'h8000_0000); end
    // low byte 0x00 is even parity
    vectors++;
    if (alu_flags !== 5'b11100) begin miscompares++; $display("FAIL ovf_flags got %b want %b", alu_flags, 5'b11100); end
    load(32'hFFFF_FFFF, 32'h1);
    #1;
    vectors++;
    if (alu_out !== 32'h0) begin miscompares++; $display("FAIL zero_out got %h want %h", alu_out, 32'h0); end
    vectors++;
    if (alu_flags !== 5'b10011) begin miscompares++; $display("FAIL zero_flags got %b want %b", alu_flags, 5'b10011); end
  endtask

  task automatic test_gating_reset_priority();
    load(32'd5, 32'd6);
    t1_oe = 1'b0; alu_opcode = 4'h0;
    #1;
    vectors++;
    if (t1_out !== 32'h0) begin miscompares++; $display("FAIL gate_t1 got %h want %h", t1_out, 32'h0); end
    vectors++;
    if (alu_out !== 32'd6) begin miscompares++; $display("FAIL gate_add got %h want %h", alu_out, 32'd6); end
    t1_oe = 1'b1;
    rst = 1'b1; t1_in = 32'd9; t2_in = 32'd9; t1_we = 1'b1; t2_we = 1'b1;
    tick();
    rst = 1'b0; t1_we = 1'b0; t2_we = 1'b0;
    #1;
    vectors++;
    if (t1_out !== 32'h0) begin miscompares++; $display("FAIL rst_prio_t1 got %h want %h", t1_out, 32'h0); end
    vectors++;
    if (t2_out !== 32'h0) begin miscompares++; $display("FAIL rst_prio_t2 got %h want %h", t2_out, 32'h0); end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops  [3] = '{4'h8, 4'hA, 4'hC};
    logic [31:0] want [3] = '{32'h0000_0002, 32'hC000_0000, 32'hC000_0000};
    t1_oe = 1'b1; t2_oe = 1'b1; alu_oe = 1'b1;
    load(32'h8000_0001, 32'h1);
    for (int i = 0; i < 3; i++) begin
      alu_opcode = ops[i];
      #1;
      vectors++;
      if (alu_out !== want[i]) begin miscompares++; $display("FAIL shift_op%h_out got %h want %h", ops[i], alu_out, want[i]); end
      vectors++;
      if (alu_flags[0] !== 1'b1) begin miscompares++; $display("FAIL shift_op%h_c got %b want %b", ops[i], alu_flags[0], 1'b1); end
    end
    // zero shift amount leaves C clear
    load(32'h8000_0001, 32'h20);
    alu_opcode = 4'h8;
    #1;
    vectors++;
    if (alu_out !== 32'h8000_0001 || alu_flags[0] !== 1'b0) begin
      miscompares++; $display("FAIL shift_zero got %h c=%b want %h c=0", alu_out, alu_flags[0], 32'h8000_0001);
    end
  endtask

  task automatic test_random();
    logic [31:0] q1 = 32'h0, q2 = 32'h0;
    logic [31:0] ea, eb, er, eo;
    logic [4:0]  ef;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      t1_we = 1'($urandom_range(0, 1));
      t2_we = 1'($urandom_range(0, 1));
      t1_in = $urandom;
      t2_in = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      tick();
      if (t1_we) q1 = t1_in;
      if (t2_we) q2 = t2_in;
      t1_we = 1'b0; t2_we = 1'b0;
      t1_oe = ($urandom_range(0, 7) != 0);
      t2_oe = ($urandom_range(0, 7) != 0);
      alu_oe = ($urandom_range(0, 3) != 0);
      alu_opcode = 4'($urandom_range(0, 15));
      alu_carry = 1'($urandom_range(0, 1));
      #1;
      ea = t1_oe ? q1 : 32'h0;
      eb = t2_oe ? q2 : 32'h0;
      ref_alu(alu_opcode, ea, eb, alu_carry, er, ef);
      eo = alu_oe ? er : 32'h0;
      vectors++;
      if (t1_out !== ea || t2_out !== eb) begin
        miscompares++; $display("FAIL rnd_regs[%0d] got %h/%h want %h/%h", i, t1_out, t2_out, ea, eb);
      end
      vectors++;
      if (alu_out !== eo) begin
        miscompares++; $display("FAIL rnd_out[%0d] op %h a %h b %h ci %b got %h want %h", i, alu_opcode, ea, eb, alu_carry, alu_out, eo);
      end
      vectors++;
      if (alu_flags !== ef) begin
        miscompares++; $display("FAIL rnd_flags[%0d] op %h a %h b %h ci %b got %b want %b", i, alu_opcode, ea, eb, alu_carry, alu_flags, ef);
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_write_hold();
    test_add();
    test_sub_borrow();
    test_overflow_zero();
    test_gating_reset_priority();
    test_shifts();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/t_reg_alu_datapath.md
Name: t_reg_alu_datapath

Overview:
- CPU execution datapath slice: two word-wide temporary registers (T1, T2) feed a combinational ALU.
- The CPU control FSM drives the write/output enables, loads T1/T2, and reads the ALU result and flags.
- No internal state except the two registers.

Parameters:
- WORD_WIDTH, 32, width of registers, operands and result.
- FLAG_WIDTH, 5, width of the flag vector; fixed at 5, other values unsupported.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- t1_we  in  1  load T1 from t1_in at next posedge.
- t1_oe  in  1  drive T1 contents onto t1_out.
- t1_in  in  WORD_WIDTH  T1 write data.
- t1_out  out  WORD_WIDTH  T1 read data; ALU operand A.
- t2_we, t2_oe, t2_in, t2_out: same as T1, for T2; t2_out is ALU operand B.
- alu_oe  in  1  drive ALU result onto alu_out.
- alu_opcode  in  4  operation select.
- alu_carry  in  1  carry/borrow in for ADC/SBB.
- alu_out  out  WORD_WIDTH  ALU result.
- alu_flags  out  5  {P,V,S,Z,C}, bit0 = C.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Register (each): on posedge clk, if rst then q<=0; else if we then q<=in; else hold.
  - rst wins over a simultaneous we.
  - Write latency is 1 cycle: data is visible on out from the cycle after the write edge.
- Read: out = oe ? q : 0. This is combinational, with no tri-state; oe does not affect stored contents.
- After reset, and while oe=0, t1_out and t2_out are 0.
- ALU: purely combinational. A = t1_out, B = t2_out, so the gated values apply: a disabled register presents 0.
- alu_out = alu_oe ? result : 0. Flags are always computed, independent of alu_oe.
- Opcodes (result; C):
  - 0 ADD: A+B; C = carry out.
  - 1 ADC: A+B+alu_carry; C = carry out.
  - 2 SUB: A-B; C = borrow (A<B unsigned).
  - 3 SBB: A-B-alu_carry; C = borrow.
  - 4 AND, 5 OR, 6 XOR, 7 NOT A: bitwise; C = 0.
  - 8 SHL: A<<B[log2(W)-1:0].
  - 9 SHR: logical right.
  - A SAR: arithmetic right.
  - B ROL, C ROR: rotate.
  - Shifts/rotates: C = last bit shifted or rotated out; C = 0 when the amount is 0.
  - D INC: A+1; C = carry out.
  - E DEC: A-1; C = borrow.
  - F PASS: result = A; C = 0.
- Z = (result==0). S = result[MSB]. P = even parity of result[7:0] (1 when even).
- V: signed overflow for ADD/ADC/INC (operands same sign, result sign differs) and SUB/SBB/DEC (operand signs differ, result sign differs from A); 0 for all other ops.
- All arithmetic is modulo 2^WORD_WIDTH. The carry is taken from a WORD_WIDTH+1-bit sum.
- No undefined outputs: every opcode has a default assignment, so no latches are inferred.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams ALU_ADD..ALU_PASS;
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_S=2, FLAG_V=3, FLAG_P=4;
  - the WORD_WIDTH default.
- One sub-module, temp_reg (parameterized register with oe/we), instantiated twice.
- The ALU logic lives in the top as a combinational block.

Test Plan:
- Reset then write: rst 1 cycle; t1_in=5, t2_in=6, we=1 for 1 cycle; next cycle oe=1 -> t1_out=5, t2_out=6, and the values are held on following cycles.
- ADD: T1=5, T2=6, oe both, alu_oe=1, opcode 0 -> alu_out=11, flags=0. Same with alu_oe=0 -> alu_out=0, flags unchanged.
- SUB borrow: T1=5, T2=6, opcode 2 -> alu_out=0xFFFFFFFF; C=1, S=1, Z=0, V=0, P=1.
- Overflow/zero: T1=0x7FFFFFFF, T2=1, ADD -> 0x80000000, V=1, S=1. T1=0xFFFFFFFF, T2=1, ADD -> 0, C=1, Z=1.
- Gating/reset priority: t1_oe=0 -> t1_out=0 and ADD gives A=0. rst=1 with we=1 and in=9 on the same edge -> register reads 0.
- Shifts: T1=0x80000001, T2=1: SHL -> 0x00000002, C=1; SAR -> 0xC0000000, C=1; ROR -> 0xC0000000, C=1.
